t_counter_ctrl: RTL and testbench

- Controller that sequences a bank of WIDTH toggle-type state bits as a programmable up/down modulo counter.
- Each cycle it computes the per-bit toggle-enable vector, applies it to its internal T-style count register, and runs a start/stop/done control FSM around the count.
- Used wherever the design needs a bounded event counter or timer built on toggle flops.
- The t_vec output can drive an external bank of toggle flip-flops directly.

---
 rtl/t_counter_ctrl.sv | 110 +++++++++++
 tb/tb_t_counter_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/t_counter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : t_counter_ctrl                                               |
// | Description : Up/down modulo counter built on toggle enables, with a       |
// |               start/stop/done controller. Define T_COUNTER_AUTO_RELOAD_EN  |
// |               to keep running across terminal counts instead of one-shot.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module t_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             stop,
    input  logic             up,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] t_vec,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0]       S_IDLE = 2'd0;
    localparam logic [1:0]       S_RUN  = 2'd1;
    localparam logic [1:0]       S_DONE = 2'd2;
    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_up;
    logic             r_busy;
    logic             r_done;
    logic             w_load;
    logic             w_term;
    logic             w_done_nxt;

    // Terminal value depends on direction: limit when counting up, zero when down.
    assign w_term = r_up ? (r_count == r_limit) : (r_count == C_ZERO);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                    w_count_nxt = up ? C_ZERO : limit;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_term) begin
                    w_done_nxt  = 1'b1;
                    w_count_nxt = r_up ? C_ZERO : r_limit;
`ifdef T_COUNTER_AUTO_RELOAD_EN
                    w_state_nxt = S_RUN;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_count_nxt = r_up ? (r_count + C_ONE) : (r_count - C_ONE);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Gated by clear so the toggle lines are quiet while reset is applied.
    assign t_vec = clear ? C_ZERO : (r_count ^ w_count_nxt);

    always_ff @(negedge clock or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_count <= C_ZERO;
            r_limit <= C_ZERO;
            r_up    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= r_count ^ t_vec;
            if (w_load) begin
                r_limit <= limit;
                r_up    <= up;
            end
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= w_done_nxt;
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_t_counter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_t_counter_ctrl                                            |
// | Description : Self-checking bench for t_counter_ctrl (WIDTH=4).            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_t_counter_ctrl;

    localparam int WIDTH = 4;

    logic             clock;
    logic             clear;
    logic             start;
    logic             stop;
    logic             up;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] t_vec;
    logic             busy;
    logic             done;

    int n_checks;
    int n_errors;
    logic [WIDTH-1:0] m_count;

    t_counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .clear (clear),
        .start (start),
        .stop  (stop),
        .up    (up),
        .limit (limit),
        .count (count),
        .t_vec (t_vec),
        .busy  (busy),
        .done  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // State changes on falling edges; inputs are driven and outputs sampled just after rising edges.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One run: expected count walks 0..L (up) or L..0 (down); stop_at < 0 means run to terminal.
    task automatic run_check(input int lim, input bit dir, input int stop_at, input int chg_lim);
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] exp_tv;
        limit = WIDTH'(lim); up = dir; start = 1'b1; stop = 1'b0;
        #1;
        exp_tv = m_count ^ (dir ? WIDTH'(0) : WIDTH'(lim));
        n_checks++;
        if (t_vec !== exp_tv) begin
            n_errors++;
            $display("FAIL start_tvec: got %b expected %b (L=%0d up=%0d)", t_vec, exp_tv, lim, dir);
        end
        step();
        start = 1'b0; limit = WIDTH'(chg_lim); up = 1'($urandom);
        for (int i = 0; i <= lim; i++) begin
            cnt = dir ? WIDTH'(i) : WIDTH'(lim - i);
            n_checks++;
            if (count !== cnt || busy !== 1'b1 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL run_state: got count=%0d busy=%b done=%b expected count=%0d busy=1 done=0 (L=%0d up=%0d i=%0d)",
                         count, busy, done, cnt, lim, dir, i);
            end
            if (i == stop_at) begin
                stop = 1'b1;
                #1;
                n_checks++;
                if (t_vec !== '0) begin
                    n_errors++;
                    $display("FAIL stop_tvec: got %b expected 0000", t_vec);
                end
                step();
                stop = 1'b0;
                n_checks++;
                if (count !== cnt || busy !== 1'b0 || done !== 1'b0) begin
                    n_errors++;
                    $display("FAIL stop_idle: got count=%0d busy=%b done=%b expected count=%0d busy=0 done=0",
                             count, busy, done, cnt);
                end
                m_count = cnt;
                return;
            end
            if (i == lim) nxt = dir ? WIDTH'(0) : WIDTH'(lim);
            else          nxt = dir ? WIDTH'(i + 1) : WIDTH'(lim - i - 1);
            n_checks++;
            if (t_vec !== (cnt ^ nxt)) begin
                n_errors++;
                $display("FAIL run_tvec: got %b expected %b (count %0d -> %0d)", t_vec, cnt ^ nxt, cnt, nxt);
            end
            step();
        end
        cnt = dir ? WIDTH'(0) : WIDTH'(lim);
        n_checks++;
        if (count !== cnt || busy !== 1'b0 || done !== 1'b1) begin
            n_errors++;
            $display("FAIL done_state: got count=%0d busy=%b done=%b expected count=%0d busy=0 done=1",
                     count, busy, done, cnt);
        end
        start = 1'b1;
        #1;
        n_checks++;
        if (t_vec !== '0) begin
            n_errors++;
            $display("FAIL done_tvec: got %b expected 0000", t_vec);
        end
        step();
        start = 1'b0;
        n_checks++;
        if (count !== cnt || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL after_done: got count=%0d busy=%b done=%b expected count=%0d busy=0 done=0",
                     count, busy, done, cnt);
        end
        m_count = cnt;
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; stop = 1'b0; up = 1'b0; limit = '0;
        #2;
        n_checks++;
        if (count !== '0 || busy !== 1'b0 || done !== 1'b0 || t_vec !== '0) begin
            n_errors++;
            $display("FAIL reset_init: got count=%0d busy=%b done=%b t_vec=%b expected all 0", count, busy, done, t_vec);
        end
        step();
        clear = 1'b0;
        step();
        limit = 4'd9; up = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        n_checks++;
        if (count !== 4'd5 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_prerun: got count=%0d busy=%b expected count=5 busy=1", count, busy);
        end
        clear = 1'b1;
        #1;
        n_checks++;
        if (count !== '0 || busy !== 1'b0 || done !== 1'b0 || t_vec !== '0) begin
            n_errors++;
            $display("FAIL reset_async: got count=%0d busy=%b done=%b t_vec=%b expected all 0", count, busy, done, t_vec);
        end
        #1;
        clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (count !== '0 || busy !== 1'b0 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_after: got count=%0d busy=%b done=%b expected 0 0 0", count, busy, done);
            end
        end
        m_count = '0;
    endtask

    task automatic test_start_stop();
        start = 1'b1; stop = 1'b1; limit = 4'd7; up = 1'b0;
        #1;
        n_checks++;
        if (t_vec !== '0) begin
            n_errors++;
            $display("FAIL startstop_tvec: got %b expected 0000", t_vec);
        end
        step();
        start = 1'b0; stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || count !== m_count || done !== 1'b0) begin
            n_errors++;
            $display("FAIL startstop_idle: got count=%0d busy=%b done=%b expected count=%0d busy=0 done=0",
                     count, busy, done, m_count);
        end
    endtask

    task automatic test_random(input int runs);
        int lim;
        int sa;
        for (int r = 0; r < runs; r++) begin
            lim = int'($urandom_range(0, 15));
`ifdef T_COUNTER_AUTO_RELOAD_EN
            sa = int'($urandom_range(0, lim));
`else
            sa = ($urandom % 2 == 0) ? -1 : int'($urandom_range(0, lim));
`endif
            run_check(lim, 1'($urandom), sa, int'($urandom_range(0, 15)));
        end
    endtask

`ifdef T_COUNTER_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic exp_done;
        limit = 4'd2; up = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int lap = 0; lap < 3; lap++) begin
            for (int i = 0; i < 3; i++) begin
                exp_done = (lap > 0 && i == 0);
                n_checks++;
                if (count !== WIDTH'(i) || busy !== 1'b1 || done !== exp_done) begin
                    n_errors++;
                    $display("FAIL auto_run: got count=%0d busy=%b done=%b expected count=%0d busy=1 done=%b",
                             count, busy, done, i, exp_done);
                end
                step();
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL auto_stop: got count=%0d busy=%b done=%b expected count=0 busy=0 done=0", count, busy, done);
        end
        m_count = '0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_count  = '0;
        test_reset();
        test_start_stop();
`ifdef T_COUNTER_AUTO_RELOAD_EN
        test_auto_reload();
        run_check(5, 1'b1, 2, 0);
        run_check(9, 1'b0, 4, 3);
`else
        run_check(3, 1'b1, -1, 3);
        run_check(9, 1'b0, -1, 9);
        run_check(5, 1'b1, 2, 5);
        run_check(0, 1'b1, -1, 0);
        run_check(6, 1'b1, -1, 1);
        test_start_stop();
`endif
        test_random(25);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
